// File: rtl/window_3x3_gen_if.sv
// Pixel-stream / 3x3-window bundle for window_3x3_gen.
// master drives the raster stream and receives windows; slave is the window generator.
interface window_3x3_gen_if;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic       sof;
  logic       win_valid;
  logic [7:0] out1;
  logic [7:0] out2;
  logic [7:0] out3;
  logic [7:0] out4;
  logic [7:0] out5;
  logic [7:0] out6;
  logic [7:0] out7;
  logic [7:0] out8;
  logic [7:0] out9;
  logic       frame_done;

  modport master (
    output pix_valid, pix_in, sof,
    input  win_valid, out1, out2, out3, out4, out5, out6, out7, out8, out9, frame_done
  );

  modport slave (
    input  pix_valid, pix_in, sof,
    output win_valid, out1, out2, out3, out4, out5, out6, out7, out8, out9, frame_done
  );
endinterface

// File: rtl/window_3x3_gen.sv
// Raster-stream 3x3 sliding-window generator with two line buffers.
// Define WIN_BORDER_SUPPRESS_EN to flag only windows lying fully inside the image.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128
) (
  input logic             CLK,
  input logic             RST_N,
  window_3x3_gen_if.slave pix_if
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    win_q [9];
  logic [7:0]    win_d [9];
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [7:0]    lb0_q [IMG_WIDTH];
  logic [7:0]    lb1_q [IMG_WIDTH];

  logic          accept;
  logic [CW-1:0] col_acc;
  logic [RW-1:0] row_acc;
  logic [7:0]    lb0_rd;
  logic [7:0]    lb1_rd;
  logic          in_rows;
  logic          in_cols;

  // sof overrides the counters so the accepted pixel is always tagged (0,0)
  always_comb begin
    accept  = pix_if.pix_valid;
    col_acc = pix_if.sof ? '0 : col_q;
    row_acc = pix_if.sof ? '0 : row_q;
    lb0_rd  = lb0_q[col_acc];
    lb1_rd  = lb1_q[col_acc];
    in_rows = (row_acc >= RW'(2));
`ifdef WIN_BORDER_SUPPRESS_EN
    in_cols = (col_acc >= CW'(2));
`else
    in_cols = 1'b1;
`endif
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_if.pix_in;

      if (col_acc == COL_LAST) begin
        col_d = '0;
        row_d = (row_acc == ROW_LAST) ? '0 : row_acc + RW'(1);
      end else begin
        col_d = col_acc + CW'(1);
        row_d = row_acc;
      end

      win_valid_d  = in_rows && in_cols;
      frame_done_d = (row_acc == ROW_LAST) && (col_acc == COL_LAST);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers keep their contents through reset; lb1 takes lb0's old value at the same index
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb1_q[col_acc] <= lb0_rd;
      lb0_q[col_acc] <= pix_if.pix_in;
    end
  end

  assign pix_if.win_valid  = win_valid_q;
  assign pix_if.frame_done = frame_done_q;
  assign pix_if.out1       = win_q[0];
  assign pix_if.out2       = win_q[1];
  assign pix_if.out3       = win_q[2];
  assign pix_if.out4       = win_q[3];
  assign pix_if.out5       = win_q[4];
  assign pix_if.out6       = win_q[5];
  assign pix_if.out7       = win_q[6];
  assign pix_if.out8       = win_q[7];
  assign pix_if.out9       = win_q[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed self-checking bench for window_3x3_gen on a 4x4 image.
// Expected windows come from a stream-history model: each column is the pixel W and 2W accepts back.
module tb_window_3x3_gen;

  localparam int W = 4;
  localparam int H = 4;
`ifdef WIN_BORDER_SUPPRESS_EN
  localparam int PULSES_PER_FRAME = 4;
`else
  localparam int PULSES_PER_FRAME = 8;
`endif

  logic CLK;
  logic RST_N;
  window_3x3_gen_if w ();

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .pix_if(w)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] win [9];
  assign win[0] = w.out1;
  assign win[1] = w.out2;
  assign win[2] = w.out3;
  assign win[3] = w.out4;
  assign win[4] = w.out5;
  assign win[5] = w.out6;
  assign win[6] = w.out7;
  assign win[7] = w.out8;
  assign win[8] = w.out9;

  int tests_run = 0;
  int failed    = 0;

  logic [7:0] first_c [9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
  logic [7:0] last_c  [9] = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};

  logic [7:0] hist [0:127];
  int         hn;
  int         mr, mc;
  logic [7:0] exp_win [9];
  bit         exp_known [9];
  bit         exp_valid, exp_done;

  task automatic model_reset();
    hn = 0; mr = 0; mc = 0;
    exp_valid = 1'b0; exp_done = 1'b0;
    for (int k = 0; k < 9; k++) begin exp_win[k] = 8'h00; exp_known[k] = 1'b0; end
  endtask

  task automatic model_accept(input logic [7:0] p, input bit s);
    int er, ec, idx;
    if (s) begin hn = 0; mr = 0; mc = 0; end
    er = mr; ec = mc;
    hist[hn] = p;
    for (int rr = 0; rr < 3; rr++) begin
      for (int j = 0; j < 3; j++) begin
        idx = hn - (2 - j) - (2 - rr) * W;
        exp_known[rr*3+j] = (idx >= 0);
        exp_win[rr*3+j]   = (idx >= 0) ? hist[idx] : 8'h00;
      end
    end
`ifdef WIN_BORDER_SUPPRESS_EN
    exp_valid = (er >= 2) && (ec >= 2);
`else
    exp_valid = (er >= 2);
`endif
    exp_done = (er == H - 1) && (ec == W - 1);
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else mc++;
    if (hn < 127) hn++;
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] p);
    w.pix_valid = v; w.sof = s; w.pix_in = p;
    if (v) model_accept(p, s);
    else begin exp_valid = 1'b0; exp_done = 1'b0; end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    w.pix_valid = 1'b0; w.sof = 1'b0; w.pix_in = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if (w.win_valid !== 1'b0) begin failed++; $display("FAIL reset win_valid got %0b exp 0", w.win_valid); end
    tests_run++;
    if (w.frame_done !== 1'b0) begin failed++; $display("FAIL reset frame_done got %0b exp 0", w.frame_done); end
    for (int k = 0; k < 9; k++) begin
      tests_run++;
      if (win[k] !== 8'h00) begin failed++; $display("FAIL reset out%0d got %02h exp 00", k + 1, win[k]); end
    end
    RST_N = 1'b1;
    model_reset();
    @(posedge CLK); #1;
  endtask

  task automatic test_frame();
    int pulses = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, i == 0, 8'((i / W) * 16 + (i % W)));
      if (w.win_valid === 1'b1) pulses++;
      tests_run++;
      if (w.win_valid !== exp_valid) begin failed++; $display("FAIL frame win_valid i=%0d got %0b exp %0b", i, w.win_valid, exp_valid); end
      tests_run++;
      if (w.frame_done !== exp_done) begin failed++; $display("FAIL frame frame_done i=%0d got %0b exp %0b", i, w.frame_done, exp_done); end
      if (exp_valid) for (int k = 0; k < 9; k++) if (exp_known[k]) begin
        tests_run++;
        if (win[k] !== exp_win[k]) begin failed++; $display("FAIL frame out%0d i=%0d got %02h exp %02h", k + 1, i, win[k], exp_win[k]); end
      end
      if (i == 10 || i == 15) for (int k = 0; k < 9; k++) begin
        tests_run++;
        if (win[k] !== ((i == 10) ? first_c[k] : last_c[k])) begin
          failed++; $display("FAIL frame_const out%0d i=%0d got %02h exp %02h", k + 1, i, win[k], (i == 10) ? first_c[k] : last_c[k]);
        end
      end
    end
    step(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (w.win_valid !== 1'b0) begin failed++; $display("FAIL frame idle_valid got %0b exp 0", w.win_valid); end
    tests_run++;
    if (pulses != PULSES_PER_FRAME) begin failed++; $display("FAIL frame pulse_count got %0d exp %0d", pulses, PULSES_PER_FRAME); end
  endtask

  task automatic test_toggle_valid();
    int pulses = 0;
    bit prev = 1'b0;
    for (int i = 0; i < 2 * W * H; i++) begin
      int n = i / 2;
      step(i % 2 == 0, i == 0, 8'((n / W) * 16 + (n % W)));
      if (w.win_valid === 1'b1) pulses++;
      tests_run++;
      if (w.win_valid === 1'b1 && prev) begin failed++; $display("FAIL toggle consecutive_valid i=%0d got 1 exp 0", i); end
      prev = (w.win_valid === 1'b1);
      tests_run++;
      if (w.win_valid !== exp_valid) begin failed++; $display("FAIL toggle win_valid i=%0d got %0b exp %0b", i, w.win_valid, exp_valid); end
      tests_run++;
      if (w.frame_done !== exp_done) begin failed++; $display("FAIL toggle frame_done i=%0d got %0b exp %0b", i, w.frame_done, exp_done); end
      if (exp_valid) for (int k = 0; k < 9; k++) if (exp_known[k]) begin
        tests_run++;
        if (win[k] !== exp_win[k]) begin failed++; $display("FAIL toggle out%0d i=%0d got %02h exp %02h", k + 1, i, win[k], exp_win[k]); end
      end
      if (i == 20 || i == 30) for (int k = 0; k < 9; k++) begin
        tests_run++;
        if (win[k] !== ((i == 20) ? first_c[k] : last_c[k])) begin
          failed++; $display("FAIL toggle_const out%0d i=%0d got %02h exp %02h", k + 1, i, win[k], (i == 20) ? first_c[k] : last_c[k]);
        end
      end
    end
    tests_run++;
    if (pulses != PULSES_PER_FRAME) begin failed++; $display("FAIL toggle pulse_count got %0d exp %0d", pulses, PULSES_PER_FRAME); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int pulses = 0;
    for (int i = 0; i < 2 * W * H; i++) begin
      int n = i % (W * H);
      step(1'b1, i == 0, 8'((n / W) * 16 + (n % W) + ((i >= W * H) ? 8'h40 : 8'h00)));
      if (w.frame_done === 1'b1) dones++;
      if (w.win_valid === 1'b1) pulses++;
      tests_run++;
      if (w.win_valid !== exp_valid) begin failed++; $display("FAIL b2b win_valid i=%0d got %0b exp %0b", i, w.win_valid, exp_valid); end
      tests_run++;
      if (w.frame_done !== exp_done) begin failed++; $display("FAIL b2b frame_done i=%0d got %0b exp %0b", i, w.frame_done, exp_done); end
      if (exp_valid) for (int k = 0; k < 9; k++) if (exp_known[k]) begin
        tests_run++;
        if (win[k] !== exp_win[k]) begin failed++; $display("FAIL b2b out%0d i=%0d got %02h exp %02h", k + 1, i, win[k], exp_win[k]); end
      end
    end
    tests_run++;
    if (dones != 2) begin failed++; $display("FAIL b2b frame_done_count got %0d exp 2", dones); end
    tests_run++;
    if (pulses != 2 * PULSES_PER_FRAME) begin failed++; $display("FAIL b2b pulse_count got %0d exp %0d", pulses, 2 * PULSES_PER_FRAME); end
  endtask

  task automatic test_sof_restart();
    int dones = 0;
    int early = 0;
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 8'((i / W) * 16 + (i % W)));
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, i == 0, 8'(8'h80 + (i / W) * 16 + (i % W)));
      if (w.frame_done === 1'b1) dones++;
      if (i < 2 * W && w.win_valid === 1'b1) early++;
      tests_run++;
      if (w.win_valid !== exp_valid) begin failed++; $display("FAIL sof win_valid i=%0d got %0b exp %0b", i, w.win_valid, exp_valid); end
      tests_run++;
      if (w.frame_done !== exp_done) begin failed++; $display("FAIL sof frame_done i=%0d got %0b exp %0b", i, w.frame_done, exp_done); end
      if (exp_valid) for (int k = 0; k < 9; k++) if (exp_known[k]) begin
        tests_run++;
        if (win[k] !== exp_win[k]) begin failed++; $display("FAIL sof out%0d i=%0d got %02h exp %02h", k + 1, i, win[k], exp_win[k]); end
      end
    end
    tests_run++;
    if (early != 0) begin failed++; $display("FAIL sof early_valid got %0d exp 0", early); end
    tests_run++;
    if (dones != 1) begin failed++; $display("FAIL sof frame_done_count got %0d exp 1", dones); end
  endtask

  task automatic test_reset_mid_row2();
    int dones = 0;
    for (int i = 0; i < 2 * W + 2; i++) step(1'b1, i == 0, 8'((i / W) * 16 + (i % W)));
    tests_run++;
    if (w.out9 !== 8'h21) begin failed++; $display("FAIL rst_mid pre_out9 got %02h exp 21", w.out9); end
    w.pix_valid = 1'b0; w.sof = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    tests_run++;
    if (w.win_valid !== 1'b0 || w.frame_done !== 1'b0) begin
      failed++; $display("FAIL rst_mid async_flags got %0b%0b exp 00", w.win_valid, w.frame_done);
    end
    for (int k = 0; k < 9; k++) begin
      tests_run++;
      if (win[k] !== 8'h00) begin failed++; $display("FAIL rst_mid async_out%0d got %02h exp 00", k + 1, win[k]); end
    end
    model_reset();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 1'b0, 8'(8'h50 + (i / W) * 16 + (i % W)));
      if (w.frame_done === 1'b1) dones++;
      tests_run++;
      if (w.win_valid !== exp_valid) begin failed++; $display("FAIL rst_mid win_valid i=%0d got %0b exp %0b", i, w.win_valid, exp_valid); end
      tests_run++;
      if (w.frame_done !== exp_done) begin failed++; $display("FAIL rst_mid frame_done i=%0d got %0b exp %0b", i, w.frame_done, exp_done); end
      if (exp_valid) for (int k = 0; k < 9; k++) if (exp_known[k]) begin
        tests_run++;
        if (win[k] !== exp_win[k]) begin failed++; $display("FAIL rst_mid out%0d i=%0d got %02h exp %02h", k + 1, i, win[k], exp_win[k]); end
      end
    end
    tests_run++;
    if (dones != 1) begin failed++; $display("FAIL rst_mid frame_done_count got %0d exp 1", dones); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_frame();
    test_toggle_valid();
    test_back_to_back();
    test_sof_restart();
    test_reset_mid_row2();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
